// File: rtl/adder_tree_arb.sv
`default_nettype none
// ============================================================================
//  Module   : adder_tree_arb
//  Purpose  : Shares one pipelined adder tree between NUM_REQ requesters at
//             packet granularity. Packets are granted round-robin. Each beat
//             is tagged with {requester id, user ctl} on the tree ctl bus.
//             The per-beat tree sums are accumulated into one sum per packet
//             and queued in a result FIFO. The tree cannot backpressure, so
//             FIFO space is reserved by a credit at grant time.
//  Ports    : i_clk, i_rst            clock, synchronous active-high reset
//             i_terms/i_val/i_sop/    per-requester beat (slice r = req r)
//             i_eop/i_ctl, o_rdy
//             o_tree_*                beat issued to the tree (no added delay)
//             i_tree_*                beat sums returned by the tree
//             o_val/o_s/o_id/o_ctl,   packet result stream (FIFO head)
//             i_rdy
//  Revision : 1.0  initial release
// ============================================================================
module adder_tree_arb #(
   parameter int NUM_REQ      = 4,
   parameter int NUM_ELEMENTS = 8,
   parameter int BIT_LEN      = 16,
   parameter int CTL_BITS     = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int ID_BITS      = $clog2(NUM_REQ)
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic [NUM_REQ*NUM_ELEMENTS*BIT_LEN-1:0] i_terms,
   input  logic [NUM_REQ-1:0]                    i_val,
   input  logic [NUM_REQ-1:0]                    i_sop,
   input  logic [NUM_REQ-1:0]                    i_eop,
   input  logic [NUM_REQ*CTL_BITS-1:0]           i_ctl,
   output logic [NUM_REQ-1:0]                    o_rdy,
   output logic [NUM_ELEMENTS*BIT_LEN-1:0]       o_tree_terms,
   output logic                                  o_tree_val,
   output logic                                  o_tree_sop,
   output logic                                  o_tree_eop,
   output logic [ID_BITS+CTL_BITS-1:0]           o_tree_ctl,
   output logic                                  o_tree_rdy,
   input  logic                                  i_tree_val,
   input  logic                                  i_tree_sop,
   input  logic                                  i_tree_eop,
   input  logic [ID_BITS+CTL_BITS-1:0]           i_tree_ctl,
   input  logic [BIT_LEN-1:0]                    i_tree_s,
   output logic                                  o_val,
   output logic [BIT_LEN-1:0]                    o_s,
   output logic [ID_BITS-1:0]                    o_id,
   output logic [CTL_BITS-1:0]                   o_ctl,
   input  logic                                  i_rdy
);

   localparam int c_beat_w  = NUM_ELEMENTS * BIT_LEN;
   localparam int c_cred_w  = $clog2(FIFO_DEPTH + 1);
   localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
   localparam int c_entry_w = BIT_LEN + ID_BITS + CTL_BITS;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ID_BITS-1:0]   r_owner;
   logic [ID_BITS-1:0]   r_rr_ptr;
   logic [ID_BITS-1:0]   w_pick;
   logic [ID_BITS-1:0]   w_cand;
   logic [NUM_REQ-1:0]   w_req;
   logic                 w_any_req;
   logic                 w_grant;
   logic                 w_busy;
   logic                 w_own_val;
   logic                 w_own_sop;
   logic                 w_own_eop;
   logic [c_cred_w-1:0]  r_credits;

   logic [BIT_LEN-1:0]   r_acc;
   logic [BIT_LEN-1:0]   w_acc_nxt;
   logic [ID_BITS-1:0]   r_acc_id;
   logic [ID_BITS-1:0]   w_id_nxt;
   logic [CTL_BITS-1:0]  r_acc_ctl;
   logic [CTL_BITS-1:0]  w_ctl_nxt;
   logic                 r_acc_open;
   logic                 w_beat_ok;
   logic                 w_push;
   logic                 w_pop;

   logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cred_w-1:0]  r_count;

   // ------------------------------------------------------------------------
   // Arbitration: only sop beats request, so a stray mid-packet beat can
   // never win a grant.
   // ------------------------------------------------------------------------
   assign w_req = i_val & i_sop;

   // Scan from the farthest offset down to rr_ptr so the last hit is the
   // first requester at or after rr_ptr.
   always_comb begin
      w_any_req = 1'b0;
      w_pick    = '0;
      w_cand    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_cand = ID_BITS'((int'(r_rr_ptr) + i) % NUM_REQ);
         if (w_req[w_cand]) begin
            w_any_req = 1'b1;
            w_pick    = w_cand;
         end
      end
   end

   assign w_busy  = (r_state == S_BUSY);
   assign w_grant = (r_state == S_IDLE) && w_any_req && (r_credits != '0);

   // ------------------------------------------------------------------------
   // Issue path: pure mux from the registered owner, no latency added.
   // ------------------------------------------------------------------------
   assign w_own_val = i_val[r_owner];
   assign w_own_sop = i_sop[r_owner];
   assign w_own_eop = i_eop[r_owner];

   always_comb begin
      o_rdy = '0;
      if (w_busy) begin
         o_rdy[r_owner] = 1'b1;
      end
   end

   assign o_tree_terms = i_terms[int'(r_owner) * c_beat_w +: c_beat_w];
   assign o_tree_val   = w_busy & w_own_val;
   assign o_tree_sop   = w_busy & w_own_val & w_own_sop;
   assign o_tree_eop   = w_busy & w_own_val & w_own_eop;
   assign o_tree_ctl   = {r_owner, i_ctl[int'(r_owner) * CTL_BITS +: CTL_BITS]};
   assign o_tree_rdy   = 1'b1;

   // ------------------------------------------------------------------------
   // Packet FSM
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_state_nxt = S_BUSY;
         S_BUSY:  if (w_own_val && w_own_eop) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_owner  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_owner  <= w_pick;
            r_rr_ptr <= (w_pick == ID_BITS'(NUM_REQ - 1)) ? '0 : w_pick + ID_BITS'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Credits: one FIFO slot is reserved per granted packet and returned when
   // its result leaves the FIFO.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_credits <= c_cred_w'(FIFO_DEPTH);
      end else if (w_grant && !w_pop) begin
         r_credits <= r_credits - c_cred_w'(1);
      end else if (!w_grant && w_pop) begin
         r_credits <= r_credits + c_cred_w'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Accumulator. A non-sop beat with no open packet is a leftover from
   // before a reset and is dropped without pushing.
   // ------------------------------------------------------------------------
   assign w_acc_nxt = i_tree_sop ? i_tree_s : r_acc + i_tree_s;
   assign w_id_nxt  = i_tree_sop ? i_tree_ctl[CTL_BITS +: ID_BITS] : r_acc_id;
   assign w_ctl_nxt = i_tree_sop ? i_tree_ctl[CTL_BITS-1:0] : r_acc_ctl;
   assign w_beat_ok = i_tree_val & (i_tree_sop | r_acc_open);
   assign w_push    = w_beat_ok & i_tree_eop;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc      <= '0;
         r_acc_id   <= '0;
         r_acc_ctl  <= '0;
         r_acc_open <= 1'b0;
      end else if (w_beat_ok) begin
         r_acc      <= w_acc_nxt;
         r_acc_id   <= w_id_nxt;
         r_acc_ctl  <= w_ctl_nxt;
         r_acc_open <= ~i_tree_eop;
      end
   end

   // ------------------------------------------------------------------------
   // Result FIFO
   // ------------------------------------------------------------------------
   assign o_val = (r_count != '0);
   assign w_pop = o_val & i_rdy;
   assign {o_s, o_id, o_ctl} = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {w_acc_nxt, w_id_nxt, w_ctl_nxt};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         if (w_push && !w_pop)      r_count <= r_count + c_cred_w'(1);
         else if (!w_push && w_pop) r_count <= r_count - c_cred_w'(1);
      end
   end

   // The credit scheme guarantees a slot for every push.
   a_fifo_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(w_push && (r_count == c_cred_w'(FIFO_DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_tree_arb
//  Purpose  : Self-checking bench for adder_tree_arb with a behavioural
//             3-stage adder tree and a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_tree_arb;

   localparam int NR = 4, NE = 8, BL = 16, CB = 8, FD = 4, IB = 2;
   localparam int TL = 3;
   localparam int LIMIT = 1000;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NR*NE*BL-1:0] i_terms = '0;
   logic [NR-1:0]       i_val = '0, i_sop = '0, i_eop = '0;
   logic [NR*CB-1:0]    i_ctl = '0;
   logic                i_rdy = 1'b1;
   logic [NR-1:0]       o_rdy;
   logic [NE*BL-1:0]    o_tree_terms;
   logic                o_tree_val, o_tree_sop, o_tree_eop, o_tree_rdy;
   logic [IB+CB-1:0]    o_tree_ctl;
   logic                t_val, t_sop, t_eop;
   logic [IB+CB-1:0]    t_ctl;
   logic [BL-1:0]       t_s;
   logic                o_val;
   logic [BL-1:0]       o_s;
   logic [IB-1:0]       o_id;
   logic [CB-1:0]       o_ctl;

   // stale-beat injection onto the tree return path
   logic                inj_val = 1'b0;
   logic [BL-1:0]       inj_s = '0;

   int errors = 0, checks = 0, pops = 0, rdy1_hits = 0;
   logic watch1 = 1'b0;
   logic [BL+IB+CB-1:0] sb [$];
   int grant_log [$];

   adder_tree_arb #(.NUM_REQ(NR), .NUM_ELEMENTS(NE), .BIT_LEN(BL), .CTL_BITS(CB),
                    .FIFO_DEPTH(FD), .ID_BITS(IB)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_terms(i_terms), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .i_ctl(i_ctl),
      .o_rdy(o_rdy),
      .o_tree_terms(o_tree_terms), .o_tree_val(o_tree_val), .o_tree_sop(o_tree_sop),
      .o_tree_eop(o_tree_eop), .o_tree_ctl(o_tree_ctl), .o_tree_rdy(o_tree_rdy),
      .i_tree_val(t_val), .i_tree_sop(t_sop), .i_tree_eop(t_eop),
      .i_tree_ctl(t_ctl), .i_tree_s(t_s),
      .o_val(o_val), .o_s(o_s), .o_id(o_id), .o_ctl(o_ctl), .i_rdy(i_rdy)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural adder tree, TL cycles, flushed by reset ----
   logic [TL-1:0]    pv, ps, pe;
   logic [IB+CB-1:0] pc [TL];
   logic [BL-1:0]    pz [TL];

   function automatic logic [BL-1:0] beat_sum(input logic [NE*BL-1:0] t);
      logic [BL-1:0] s = '0;
      for (int k = 0; k < NE; k++) s = s + t[k*BL +: BL];
      return s;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         pv <= '0; ps <= '0; pe <= '0;
      end else begin
         pv <= {pv[TL-2:0], o_tree_val};
         ps <= {ps[TL-2:0], o_tree_sop};
         pe <= {pe[TL-2:0], o_tree_eop};
         pc[0] <= o_tree_ctl;
         pz[0] <= beat_sum(o_tree_terms);
         for (int k = 1; k < TL; k++) begin
            pc[k] <= pc[k-1];
            pz[k] <= pz[k-1];
         end
      end
   end

   assign t_val = inj_val | pv[TL-1];
   assign t_sop = inj_val ? 1'b0 : ps[TL-1];
   assign t_eop = inj_val ? 1'b1 : pe[TL-1];
   assign t_ctl = inj_val ? '0 : pc[TL-1];
   assign t_s   = inj_val ? inj_s : pz[TL-1];

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Drives one packet for requester r. Beat b, term k = base + k*step.
   // The expected result is queued when the sop beat is accepted, which is
   // grant order. stop_after < nb abandons the packet after that many beats.
   task automatic send_pkt(input int r, input int nb, input int base, input int step,
                           input logic [CB-1:0] ctl, input logic [BL-1:0] exp_s,
                           input int stop_after);
      logic acc;
      for (int b = 0; b < nb; b++) begin
         if (b == stop_after) break;
         i_val[r] = 1'b1;
         i_sop[r] = (b == 0);
         i_eop[r] = (b == nb - 1);
         i_ctl[r*CB +: CB] = ctl;
         for (int k = 0; k < NE; k++) i_terms[(r*NE + k)*BL +: BL] = BL'(base + k*step);
         acc = 1'b0;
         for (int t = 0; t < LIMIT && !acc; t++) begin
            @(negedge clk);
            if (o_rdy[r]) acc = 1'b1;
         end
         if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req %0d beat %0d not accepted in %0d cycles", r, b, LIMIT);
            i_val[r] = 1'b0; i_sop[r] = 1'b0; i_eop[r] = 1'b0;
            return;
         end
         @(posedge clk);
         if (b == 0) begin
            sb.push_back({exp_s, IB'(r), ctl});
            grant_log.push_back(r);
         end
         #1;
      end
      i_val[r] = 1'b0; i_sop[r] = 1'b0; i_eop[r] = 1'b0;
   endtask

   task automatic burst(input int r, input int n);
      for (int i = 0; i < n; i++)
         send_pkt(r, 1, r*16 + i, 0, CB'(8'hA0 + r), BL'(8*(r*16 + i)), 99);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_val = '0; i_sop = '0; i_eop = '0;
      sb.delete();
      grant_log.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [BL+IB+CB-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (watch1 && o_rdy[1]) rdy1_hits++;
            if (o_val && i_rdy) begin
               pops++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_result: got s=%h id=%0d ctl=%h, required no output",
                           o_s, o_id, o_ctl);
               end else begin
                  e = sb.pop_front();
                  if ({o_s, o_id, o_ctl} !== e)
                  begin
                     errors++;
                     $display("FAIL result: got s=%h id=%0d ctl=%h, required s=%h id=%0d ctl=%h",
                              o_s, o_id, o_ctl, e[IB+CB +: BL], e[CB +: IB], e[CB-1:0]);
                  end
               end
            end
         end
      end
   end

   initial begin
      repeat (40000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int lat, p, g0;
      int cnt [NR];
      logic found;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_o_val", o_val, 0);
      chk("reset_o_rdy", o_rdy, 0);
      chk("reset_tree_val", o_tree_val, 0);
      chk("reset_credits", dut.r_credits, FD);
      @(posedge clk); #1;

      // 1-beat packet, terms 1..8 -> 36, latency tree+1
      send_pkt(0, 1, 1, 1, 8'h5A, 16'd36, 99);
      lat = 0; found = 1'b0;
      for (int t = 1; t <= 20 && !found; t++) begin
         @(negedge clk);
         if (o_val) begin found = 1'b1; lat = t; end
      end
      chk("t1_latency", lat, TL + 1);
      repeat (3) @(negedge clk);
      chk("t1_credits_back", dut.r_credits, FD);
      chk("t1_drained", sb.size(), 0);

      // requester 2, 3 beats of 0x1000 -> 3*0x8000 mod 2^16 = 0x8000
      p = pops;
      send_pkt(2, 3, 16'h1000, 0, 8'hC3, 16'h8000, 99);
      repeat (10) @(negedge clk);
      chk("t2_one_result", pops - p, 1);

      // round-robin fairness, 40 packets
      do_reset();
      fork
         burst(0, 10); burst(1, 10); burst(2, 10); burst(3, 10);
      join
      repeat (10) @(negedge clk);
      chk("t3_grants", grant_log.size(), 40);
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      for (int i = 0; i < grant_log.size() && i < 40; i++) begin
         chk("t3_order", grant_log[i], i % NR);
         cnt[grant_log[i] % NR]++;
      end
      for (int r = 0; r < NR; r++) chk("t3_share", cnt[r], 10);
      chk("t3_drained", sb.size(), 0);

      // backpressure: credits cap grants at FIFO_DEPTH
      @(posedge clk); #1;
      g0 = grant_log.size(); p = pops;
      i_rdy = 1'b0;
      fork
         burst(0, 3); burst(1, 3); burst(2, 3); burst(3, 3);
         begin
            repeat (200) @(negedge clk);
            chk("t4_grants_held", grant_log.size() - g0, FD);
            chk("t4_o_val", o_val, 1);
            @(posedge clk); #1 i_rdy = 1'b1;
         end
      join
      repeat (20) @(negedge clk);
      chk("t4_pops", pops - p, 12);
      chk("t4_drained", sb.size(), 0);

      // reset in the middle of a packet
      @(posedge clk); #1 i_rdy = 1'b0;
      send_pkt(3, 1, 2, 0, 8'h33, 16'd16, 99);
      repeat (6) @(negedge clk);
      chk("t5_pending", o_val, 1);
      @(posedge clk); #1;
      send_pkt(0, 3, 16'h100, 1, 8'h11, 16'h0, 2);
      @(negedge clk);
      chk("t5_busy_rdy", o_rdy, 4'b0001);
      @(posedge clk); #1 rst = 1'b1;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      chk("t5_rst_o_val", o_val, 0);
      chk("t5_rst_o_rdy", o_rdy, 0);
      chk("t5_rst_tree_val", o_tree_val, 0);
      chk("t5_rst_credits", dut.r_credits, FD);
      @(posedge clk); #1 rst = 1'b0; i_rdy = 1'b1;
      inj_val = 1'b1; inj_s = 16'h1234;
      @(posedge clk); #1 inj_val = 1'b0;
      repeat (8) @(negedge clk);
      chk("t5_stale_dropped", o_val, 0);
      p = pops;
      send_pkt(1, 1, 10, 10, 8'h77, 16'd360, 99);
      repeat (10) @(negedge clk);
      chk("t5_post_reset_result", pops - p, 1);

      // val without sop is not a request
      @(posedge clk); #1;
      g0 = grant_log.size();
      i_val[1] = 1'b1; i_sop[1] = 1'b0; i_eop[1] = 1'b1;
      rdy1_hits = 0; watch1 = 1'b1;
      fork
         burst(0, 2); burst(3, 2);
      join
      repeat (10) @(negedge clk);
      watch1 = 1'b0;
      chk("t6_rdy1_low", rdy1_hits, 0);
      chk("t6_others_granted", grant_log.size() - g0, 4);
      chk("t6_drained", sb.size(), 0);
      i_val[1] = 1'b0; i_eop[1] = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adder_tree_arb.md
Name: adder_tree_arb

Overview:
- Shares one pipe_adder_tree_log_n instance between NUM_REQ requesters, at packet granularity.
- Each requester sends a packet of one or more beats. Each beat is NUM_ELEMENTS terms, framed by sop/eop.
- Grants packets round-robin and tags beats with a requester ID on the tree ctl bus.
- Accumulates per-beat tree sums into one sum per packet, buffers results in an output FIFO, and uses credits because the tree cannot backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
NUM_ELEMENTS, 8, terms per beat (equals the tree NUM_ELEMENTS)
BIT_LEN, 16, term/sum width; all arithmetic is modulo 2^BIT_LEN
CTL_BITS, 8, user ctl per packet, captured on the sop beat
FIFO_DEPTH, 4, result FIFO entries; also the credit count (power of 2, >=2)
ID_BITS, $clog2(NUM_REQ), derived requester ID width

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_terms  in  NUM_REQ*NUM_ELEMENTS*BIT_LEN  requester r's beat at slice r
i_val  in  NUM_REQ  per-requester beat valid
i_sop  in  NUM_REQ  per-requester start of packet
i_eop  in  NUM_REQ  per-requester end of packet
i_ctl  in  NUM_REQ*CTL_BITS  per-requester user ctl
o_rdy  out  NUM_REQ  per-requester beat accept
o_tree_terms  out  NUM_ELEMENTS*BIT_LEN  to tree i_terms
o_tree_val / o_tree_sop / o_tree_eop  out  1 each  to tree
o_tree_ctl  out  ID_BITS+CTL_BITS  to tree i_ctl, {id, user ctl}
o_tree_rdy  out  1  to tree i_rdy, tied 1
i_tree_val / i_tree_sop / i_tree_eop  in  1 each  from tree
i_tree_ctl  in  ID_BITS+CTL_BITS  from tree o_ctl
i_tree_s  in  BIT_LEN  from tree o_s
o_val  out  1  result valid
o_s  out  BIT_LEN  packet sum
o_id  out  ID_BITS  requester that owned the packet
o_ctl  out  CTL_BITS  user ctl from the packet's sop beat
i_rdy  in  1  downstream accept

Behaviour:
- Clock/reset: clock i_clk; synchronous active-high reset i_rst. Reset values:
  - state IDLE, rr_ptr 0, owner 0, credits FIFO_DEPTH
  - FIFO empty, acc 0, acc_open 0
  - o_val 0, o_rdy all 0, o_tree_val 0
- Requests: requester r requests when i_val[r] & i_sop[r]. A valid beat without sop while IDLE is not a request; o_rdy stays low and it stalls.
- FSM IDLE:
  - If credits>0 and any request exists, choose the first requesting index at or after rr_ptr (wrapping).
  - Register owner, set rr_ptr=owner+1 mod NUM_REQ, decrement credits, go to BUSY.
  - No beat is accepted in IDLE, so there is one bubble cycle per packet.
- FSM BUSY:
  - o_rdy[owner]=1, all other o_rdy bits 0.
  - o_tree_val = i_val[owner]. Terms, sop, eop and ctl are muxed from owner; o_tree_ctl = {owner, i_ctl[owner]}.
  - When i_val[owner] & i_eop[owner]: return to IDLE next cycle.
- Issue path: combinational from registered owner/state; no added latency into the tree.
- Credits:
  - Reserved at grant, returned on FIFO pop (o_val & i_rdy).
  - Grant and pop in the same cycle: net unchanged.
  - credits + FIFO occupancy + open packets never exceeds FIFO_DEPTH, so the FIFO never overflows.
- Accumulator, on i_tree_val:
  - sop: acc = i_tree_s; capture id and ctl from i_tree_ctl; acc_open=1.
  - not sop and acc_open: acc = acc + i_tree_s (wraps).
  - not sop and !acc_open: beat discarded (stale beat after reset).
  - eop: push {acc_next, id, ctl} to the FIFO and clear acc_open. A sop&eop beat pushes i_tree_s directly.
- FIFO: registered; head drives o_val/o_s/o_id/o_ctl. An entry is visible the cycle after the tree eop beat. Push into a full FIFO cannot occur (credit invariant); this is asserted in simulation.
- Simultaneous push and pop: occupancy unchanged; with 1 entry, the head advances to the new entry.
- Output ordering: results leave in grant order.
- Reset mid-packet: all state returns to reset values. The tree shares i_rst and flushes itself; any beat arriving with no open sop is discarded.
- Total latency: from the owner's eop beat to o_val = tree latency + 1.

Test Plan:
- Single requester, 1-beat packet, terms 1..8, sop=eop=1, ctl=0x5A -> o_val with o_s=36, o_id=0, o_ctl=0x5A; credits return to 4 after pop.
- Requester 2, 3-beat packet, all terms 0x1000 -> o_s=0x8000*3 mod 2^16=0x8000; confirm no early o_val on the non-eop beats.
- Requesters 0..3 all requesting 1-beat packets continuously, i_rdy=1 -> grants 0,1,2,3,0...; o_id follows the same order; each gets an equal share over 40 packets.
- i_rdy=0 for 200 cycles with all requesting -> exactly 4 packets granted, FIFO full, no further grants; release i_rdy -> flow resumes with no loss or duplication.
- Assert i_rst mid 3-beat packet -> all outputs reach reset values next cycle; a post-reset 1-beat packet sums correctly with no stale contribution.
- Requester 1 raises val without sop while IDLE -> never granted, o_rdy[1]=0; other requesters are unaffected.
